a2d_spi_serf: RTL and testbench

- Synthesizable SPI serf that models the DE0-Nano ADC128S-style A2D converter: the responder end of the A2D command/readback protocol.
- Receives 16-bit commands {2'b00, chnnl[2:0], 11'h000} from an SPI monarch.
- Samples the selected channel from a parallel analog-value bus when a command completes.
- Returns that 12-bit result, zero-extended to 16 bits, on MISO during the next transaction.
- Used as the A2D stand-in for the top-level bench and as an FPGA loopback target.

---
 rtl/a2d_spi_serf.sv | 102 ++++++++++
 tb/tb_a2d_spi_serf.sv | 130 +++++++++++++
 2 files changed

// File: rtl/a2d_spi_serf.sv
// a2d_spi_serf: ADC128S-style SPI responder that latches a channel on each 16-bit command and returns it next frame
module a2d_spi_serf #(
    parameter int SYNC_STAGES = 2,
    parameter int RES_W       = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SS_n,
    input  logic               SCLK,
    input  logic               MOSI,
    output logic               MISO,
    input  logic [8*RES_W-1:0] analog,
    output logic               cmd_rcvd,
    output logic [2:0]         chnnl_rcvd,
    output logic               frm_err,
    output logic [15:0]        cnv_cnt
);
    typedef enum logic [1:0] {IDLE, ACTIVE, CMPLT} state_t;
    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sclk_q, ss_q, mosi_q;
    logic                   sclk_h_q, ss_h_q;
    logic [15:0]            tx_q, cnv_cnt_q;
    logic [14:0]            rx_q;
    logic [4:0]             bit_cnt_q;
    logic [RES_W-1:0]       result_q;
    logic [2:0]             chnnl_q;
    logic                   cmd_rcvd_q, frm_err_q;
    logic                   sclk_s, ss_s, mosi_s, rise, fall, ss_fall, ss_rise;
    assign sclk_s  = sclk_q[SYNC_STAGES-1];
    assign ss_s    = ss_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_q[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_h_q;
    assign fall    = ~sclk_s & sclk_h_q;
    assign ss_fall = ~ss_s & ss_h_q;
    assign ss_rise = ss_s & ~ss_h_q;
    assign MISO       = (state_q == ACTIVE) & tx_q[15];
    assign cmd_rcvd   = cmd_rcvd_q;
    assign frm_err    = frm_err_q;
    assign chnnl_rcvd = chnnl_q;
    assign cnv_cnt    = cnv_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q   <= '1;
            ss_q     <= '1;
            mosi_q   <= '0;
            sclk_h_q <= 1'b1;
            ss_h_q   <= 1'b1;
        end else begin
            sclk_q   <= {sclk_q[SYNC_STAGES-2:0], SCLK};
            ss_q     <= {ss_q[SYNC_STAGES-2:0], SS_n};
            mosi_q   <= {mosi_q[SYNC_STAGES-2:0], MOSI};
            sclk_h_q <= sclk_s;
            ss_h_q   <= ss_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_q       <= '0;
            rx_q       <= '0;
            bit_cnt_q  <= '0;
            result_q   <= '0;
            chnnl_q    <= '0;
            cnv_cnt_q  <= '0;
            cmd_rcvd_q <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            cmd_rcvd_q <= 1'b0;
            frm_err_q  <= 1'b0;
            case (state_q)
                IDLE: if (ss_fall) begin
                    tx_q      <= {{(16-RES_W){1'b0}}, result_q};
                    bit_cnt_q <= '0;
                    state_q   <= ACTIVE;
                end
                ACTIVE: begin
                    if (ss_rise) state_q <= CMPLT;
                    // edges while SS_n is high belong to no frame
                    if (!ss_s && rise) begin
                        rx_q      <= {rx_q[13:0], mosi_s};
                        bit_cnt_q <= bit_cnt_q + {4'b0, bit_cnt_q != 5'd31};
                    end
                    if (!ss_s && fall) tx_q <= {tx_q[14:0], 1'b0};
                end
                CMPLT: begin
                    if (bit_cnt_q == 5'd16) begin
                        chnnl_q    <= rx_q[13:11];
                        result_q   <= analog[rx_q[13:11]*RES_W +: RES_W];
                        cmd_rcvd_q <= 1'b1;
                        cnv_cnt_q  <= cnv_cnt_q + 16'd1;
                    end else begin
                        frm_err_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_a2d_spi_serf.sv
// tb_a2d_spi_serf: table-driven frames with a readback scoreboard plus reset/abort/wrap sequences
module tb_a2d_spi_serf;
    logic        clk = 0, rst_n = 0, SS_n = 1, SCLK = 1, MOSI = 0;
    logic        MISO, cmd_rcvd, frm_err;
    logic [95:0] analog;
    logic [2:0]  chnnl_rcvd;
    logic [15:0] cnv_cnt;
    int          n_cmp = 0, n_bad = 0, n_cmd_p = 0, n_err_p = 0;
    logic [15:0] sb[$];

    typedef struct {
        logic [15:0] cmd;
        int          nbits;
        logic [15:0] exp_rd;
        logic        exp_ok;
        logic [2:0]  exp_ch;
        logic [15:0] exp_cnt;
    } vec_t;
    vec_t vecs[6];

    a2d_spi_serf dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .analog(analog), .cmd_rcvd(cmd_rcvd), .chnnl_rcvd(chnnl_rcvd), .frm_err(frm_err),
        .cnv_cnt(cnv_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_rcvd) n_cmd_p++;
        if (frm_err) n_err_p++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one SCLK period; MISO is captured while SCLK is still high, before the shifting fall
    task automatic sbit(input logic mosi_b, inout logic [15:0] rd);
        rd   = {rd[14:0], MISO};
        SCLK = 0;
        MOSI = mosi_b;
        tick(8);
        SCLK = 1;
        tick(8);
    endtask

    task automatic run_frame(input logic [15:0] cmd, input int nbits, input logic [15:0] exp_rd,
                             input logic exp_ok, input logic [2:0] exp_ch, input logic [15:0] exp_cnt);
        logic [15:0] rd, exp;
        int c0, e0;
        sb.push_back(exp_rd);
        c0 = n_cmd_p;
        e0 = n_err_p;
        rd = '0;
        SS_n = 0;
        tick(6);
        for (int i = 0; i < nbits; i++) sbit(cmd[15-i], rd);
        tick(4);
        SS_n = 1;
        MOSI = 0;
        tick(10);
        exp = sb.pop_front();
        chk($sformatf("miso_rd cmd=%h", cmd), {16'h0, rd}, {16'h0, exp >> (16 - nbits)});
        chk("cmd_rcvd_pulses", n_cmd_p - c0, exp_ok ? 1 : 0);
        chk("frm_err_pulses", n_err_p - e0, exp_ok ? 0 : 1);
        chk("chnnl_rcvd", {29'h0, chnnl_rcvd}, {29'h0, exp_ch});
        chk("cnv_cnt", {16'h0, cnv_cnt}, {16'h0, exp_cnt});
    endtask

    initial begin
        logic [15:0] rd;
        int c0, e0;
        analog = {12'h777, 12'h666, 12'h555, 12'h444, 12'hABC, 12'h222, 12'h111, 12'h123};
        vecs[0] = '{16'h1800, 16, 16'h0000, 1'b1, 3'd3, 16'd1};
        vecs[1] = '{16'h0000, 16, 16'h0ABC, 1'b1, 3'd0, 16'd2};
        vecs[2] = '{16'h2800, 16, 16'h0123, 1'b1, 3'd5, 16'd3};
        vecs[3] = '{16'h0000, 9,  16'h0555, 1'b0, 3'd5, 16'd3};
        vecs[4] = '{16'hFFFF, 16, 16'h0555, 1'b1, 3'd7, 16'd4};
        vecs[5] = '{16'h0000, 16, 16'h0777, 1'b1, 3'd0, 16'd5};
        tick(3);
        chk("rst_cnv_cnt", {16'h0, cnv_cnt}, 32'h0);
        chk("rst_chnnl", {29'h0, chnnl_rcvd}, 32'h0);
        chk("rst_pulses", {30'h0, cmd_rcvd, frm_err}, 32'h0);
        chk("rst_miso", {31'h0, MISO}, 32'h0);
        rst_n = 1;
        tick(3);
        foreach (vecs[i])
            run_frame(vecs[i].cmd, vecs[i].nbits, vecs[i].exp_rd, vecs[i].exp_ok,
                      vecs[i].exp_ch, vecs[i].exp_cnt);
        // analog moves between command and readback: the sampled value must stick
        run_frame(16'h2800, 16, 16'h0123, 1'b1, 3'd5, 16'd6);
        analog[5*12 +: 12] = 12'hFFF;
        run_frame(16'h0000, 16, 16'h0555, 1'b1, 3'd0, 16'd7);
        // reset in the middle of a frame
        c0 = n_cmd_p;
        e0 = n_err_p;
        rd = '0;
        SS_n = 0;
        tick(6);
        for (int i = 0; i < 8; i++) sbit(1'b0, rd);
        rst_n = 0;
        tick(3);
        SS_n = 1;
        tick(2);
        rst_n = 1;
        tick(8);
        chk("midrst_cnv_cnt", {16'h0, cnv_cnt}, 32'h0);
        chk("midrst_chnnl", {29'h0, chnnl_rcvd}, 32'h0);
        chk("midrst_pulses", n_cmd_p - c0 + n_err_p - e0, 0);
        run_frame(16'h0000, 16, 16'h0000, 1'b1, 3'd0, 16'd1);
        // counter wrap
        force dut.cnv_cnt_q = 16'hFFFF;
        tick(1);
        release dut.cnv_cnt_q;
        tick(1);
        chk("preload_cnv_cnt", {16'h0, cnv_cnt}, 32'h0000FFFF);
        run_frame(16'h3800, 16, 16'h0123, 1'b1, 3'd7, 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
